vec_mem_reader: RTL and testbench



---
 rtl/vec_mem_reader_pkg.sv | 24 ++
 rtl/vec_mem_reader_skid_fifo.sv | 57 +++++
 rtl/vec_mem_reader.sv | 128 ++++++++++++
 tb/tb_vec_mem_reader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_reader_pkg.sv
// Shared types, buffer sizing and the issue-credit helper for the strided vector read engine.
package vec_mem_reader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int FIFO_DEPTH = 2;
   localparam int RD_LATENCY = 1;
   localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam int CREDIT_W   = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

   // A read may issue only if every read already in flight plus the new one still fits the buffer.
   function automatic logic credit_ok(input logic [FCNT_W-1:0] count,
                                      input logic              inflight,
                                      input logic              pop);
      logic [CREDIT_W-1:0] used;
      used = CREDIT_W'(count) + CREDIT_W'(inflight) - CREDIT_W'(pop);
      return used < CREDIT_W'(FIFO_DEPTH);
   endfunction

endpackage

// File: rtl/vec_mem_reader_skid_fifo.sv
// Two-entry FIFO holding {last, index, data} beats between RAM capture and the output stream.
module vec_skid_fifo
   import vec_mem_reader_pkg::*;
#(
   parameter int W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [W-1:0]      din_i,
   output logic [W-1:0]      dout_o,
   output logic [FCNT_W-1:0] count_o,
   output logic              valid_o
);

   logic [W-1:0]      mem_q [FIFO_DEPTH];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0] cnt_q, cnt_d;
   logic              do_pop;

   // Flush wins over a same-cycle push or pop so an aborted transfer leaves nothing behind.
   always_comb begin
      do_pop   = pop_i && (cnt_q != '0);
      wr_ptr_d = wr_ptr_q ^ push_i;
      rd_ptr_d = rd_ptr_q ^ do_pop;
      cnt_d    = cnt_q + FCNT_W'(push_i) - FCNT_W'(do_pop);
      if (flush_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = cnt_q;
   assign valid_o = (cnt_q != '0);

endmodule

// File: rtl/vec_mem_reader.sv
// Strided read engine: walks base, base+stride, ... across N_CH lockstep RAMs and streams the
// elements out on a valid/ready interface tagged with index and last.
module vec_mem_reader
   import vec_mem_reader_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [ADDR_WIDTH-1:0]      base_addr,
   input  logic [ADDR_WIDTH-1:0]      stride,
   input  logic [CNT_WIDTH-1:0]       length,
   input  logic                       abort,
   output logic                       busy,
   output logic                       done,
   output logic                       rd_en,
   output logic [ADDR_WIDTH-1:0]      rd_addr,
   input  logic [N_CH*DATA_WIDTH-1:0] rd_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [N_CH*DATA_WIDTH-1:0] m_data,
   output logic                       m_last,
   output logic [CNT_WIDTH-1:0]       m_index
);

   localparam int DW = N_CH * DATA_WIDTH;
   localparam int EW = DW + CNT_WIDTH + 1;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] stride_q, stride_d;
   logic [CNT_WIDTH-1:0]  len_q, len_d;
   logic [CNT_WIDTH-1:0]  issued_q, issued_d;
   logic [CNT_WIDTH-1:0]  infl_idx_q;
   logic                  infl_q, infl_last_q;
   logic                  start_ok, abort_rd, pop, issue;
   logic [EW-1:0]         head;
   logic                  head_last;
   logic [FCNT_W-1:0]     fifo_cnt;
   logic                  fifo_vld;

   assign start_ok  = start && (state_q == IDLE);
   assign abort_rd  = abort && (state_q == READ);
   assign pop       = fifo_vld && m_ready;
   assign head_last = head[EW-1];
   assign issue     = (state_q == READ) && (issued_q < len_q) && credit_ok(fifo_cnt, infl_q, pop);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = (length == '0) ? DONE : READ;
         READ:    if (abort) state_d = IDLE;
                  else if (pop && head_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q != IDLE);
      done  = (state_q == DONE);
      rd_en = issue;
   end

   always_comb begin
      addr_d   = addr_q;
      stride_d = stride_q;
      len_d    = len_q;
      issued_d = issued_q;
      if (start_ok) begin
         addr_d   = base_addr;
         stride_d = stride;
         len_d    = length;
         issued_d = '0;
      end else if (issue) begin
         addr_d   = addr_q + stride_q;
         issued_d = issued_q + CNT_WIDTH'(1);
      end
   end

   // A read issued in the abort cycle is dropped here so its data never reaches the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q   <= '0;
         issued_q <= '0;
         infl_q   <= 1'b0;
      end else begin
         addr_q   <= addr_d;
         issued_q <= issued_d;
         infl_q   <= issue && !abort_rd;
      end
   end

   always_ff @(posedge clk) begin
      stride_q    <= stride_d;
      len_q       <= len_d;
      infl_idx_q  <= issued_q;
      infl_last_q <= (issued_q == len_q - CNT_WIDTH'(1));
   end

   vec_skid_fifo #(.W(EW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (abort_rd),
      .push_i  (infl_q),
      .pop_i   (pop),
      .din_i   ({infl_last_q, infl_idx_q, rd_data}),
      .dout_o  (head),
      .count_o (fifo_cnt),
      .valid_o (fifo_vld)
   );

   assign rd_addr = addr_q;
   assign m_valid = fifo_vld;
   assign m_data  = fifo_vld ? head[DW-1:0] : '0;
   assign m_index = fifo_vld ? head[DW +: CNT_WIDTH] : '0;
   assign m_last  = fifo_vld && head_last;

endmodule

// File: tb/tb_vec_mem_reader.sv
// Directed bench for vec_mem_reader against a 1-cycle RAM model (ch c, addr a -> 8'h10*(c+1)+a).
module tb_vec_mem_reader;

   localparam int N_CH       = 2;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 5;
   localparam int CNT_WIDTH  = 6;
   localparam int DW         = N_CH * DATA_WIDTH;

   logic                  clk = 1'b0;
   logic                  rst, start, abort, m_ready;
   logic [ADDR_WIDTH-1:0] base_addr, stride, rd_addr;
   logic [CNT_WIDTH-1:0]  length, m_index;
   logic                  busy, done, rd_en, m_valid, m_last;
   logic [DW-1:0]         rd_data, m_data;

   always #5 clk = ~clk;

   vec_mem_reader #(
      .N_CH(N_CH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
      .length(length), .abort(abort), .busy(busy), .done(done), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last), .m_index(m_index)
   );

   function automatic logic [DATA_WIDTH-1:0] ram_word(input int c, input logic [ADDR_WIDTH-1:0] a);
      return DATA_WIDTH'(8'h10 * (c + 1)) + DATA_WIDTH'(a);
   endfunction

   always @(posedge clk) begin
      if (rd_en)
         for (int c = 0; c < N_CH; c++) rd_data[c*DATA_WIDTH +: DATA_WIDTH] <= ram_word(c, rd_addr);
   end

   int vec_n = 0;
   int miss_n = 0;

   logic [DW-1:0]         b_data [$];
   logic [CNT_WIDTH-1:0]  b_idx  [$];
   logic                  b_last [$];
   logic [ADDR_WIDTH-1:0] a_q    [$];
   int   done_n, valid_n, hold_err, over_err, outst, cyc_n;
   int   start_c, first_v, done_c, last_c, rdy_mode, pat_k;
   logic hold_chk, h_last;
   logic [DW-1:0]        h_data;
   logic [CNT_WIDTH-1:0] h_idx;
   logic [2:0]           rdy_pat = 3'b001;
   logic [DW-1:0]         ev [8];
   logic [ADDR_WIDTH-1:0] ea [8];

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_n++;
      if (got !== exp) begin
         miss_n++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      b_data.delete(); b_idx.delete(); b_last.delete(); a_q.delete();
      done_n = 0; valid_n = 0; hold_err = 0; over_err = 0; outst = 0;
      start_c = -1; first_v = -1; done_c = -1; last_c = -1; hold_chk = 1'b0;
   endtask

   task automatic sample();
      if (start && !busy && !rst) start_c = cyc_n;
      if (m_valid && first_v < 0) first_v = cyc_n;
      if (m_valid) valid_n++;
      if (done) begin
         done_n++;
         if (done_c < 0) done_c = cyc_n;
      end
      if (hold_chk && (!m_valid || m_data !== h_data || m_index !== h_idx || m_last !== h_last))
         hold_err++;
      hold_chk = m_valid && !m_ready;
      h_data = m_data; h_idx = m_index; h_last = m_last;
      if (outst > 2) over_err++;
      if (rd_en) begin
         a_q.push_back(rd_addr);
         outst++;
      end
      if (m_valid && m_ready) begin
         b_data.push_back(m_data); b_idx.push_back(m_index); b_last.push_back(m_last);
         outst--;
         if (m_last) last_c = cyc_n;
      end
   endtask

   task automatic cyc();
      m_ready = (rdy_mode == 0) ? 1'b1 : rdy_pat[pat_k % 3];
      pat_k++;
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic start_xfer(input logic [ADDR_WIDTH-1:0] b, input logic [ADDR_WIDTH-1:0] s,
                             input logic [CNT_WIDTH-1:0] l);
      base_addr = b; stride = s; length = l; start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done_n == 0 && n < budget) begin
         cyc();
         n++;
      end
      check_vec({tag, "_done_seen"}, done_n, 1);
   endtask

   task automatic check_beats(input string tag, input int n);
      check_vec({tag, "_nbeats"}, b_data.size(), n);
      for (int k = 0; k < n; k++) begin
         if (k < b_data.size()) begin
            check_vec($sformatf("%s_data%0d", tag, k), 32'(b_data[k]), 32'(ev[k]));
            check_vec($sformatf("%s_idx%0d", tag, k), 32'(b_idx[k]), k);
            check_vec($sformatf("%s_last%0d", tag, k), 32'(b_last[k]), (k == n - 1) ? 1 : 0);
         end
      end
   endtask

   task automatic check_addrs(input string tag, input int n);
      check_vec({tag, "_nreads"}, a_q.size(), n);
      for (int k = 0; k < n; k++)
         if (k < a_q.size()) check_vec($sformatf("%s_addr%0d", tag, k), 32'(a_q[k]), 32'(ea[k]));
   endtask

   task automatic check_reset_outs(input string tag);
      check_vec({tag, "_ctrl"}, {busy, done, rd_en, m_valid, m_last}, 0);
      check_vec({tag, "_rd_addr"}, 32'(rd_addr), 0);
      check_vec({tag, "_m_index"}, 32'(m_index), 0);
      check_vec({tag, "_m_data"}, 32'(m_data), 0);
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
      base_addr = '0; stride = '0; length = '0;
      rdy_mode = 0; pat_k = 0; cyc_n = 0;
      clear_mon();
      cyc(); cyc();
      check_reset_outs("reset");
      rst = 1'b0;
      cyc();

      // Unit stride, full throughput
      clear_mon();
      start_xfer(5'd0, 5'd1, 6'd4);
      wait_done("t1", 40);
      cyc();
      ev = '{16'h2010, 16'h2111, 16'h2212, 16'h2313, 16'h0, 16'h0, 16'h0, 16'h0};
      ea = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0};
      check_beats("t1", 4);
      check_addrs("t1", 4);
      check_vec("t1_first_valid_lat", first_v - start_c, 3);
      check_vec("t1_done_after_last", done_c - last_c, 1);
      check_vec("t1_done_count", done_n, 1);
      check_vec("t1_busy_after", busy, 0);

      // Address wrap-around
      clear_mon();
      start_xfer(5'd30, 5'd3, 6'd4);
      wait_done("t2", 40);
      cyc();
      ev = '{16'h3E2E, 16'h2111, 16'h2414, 16'h2717, 16'h0, 16'h0, 16'h0, 16'h0};
      ea = '{5'd30, 5'd1, 5'd4, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0};
      check_beats("t2", 4);
      check_addrs("t2", 4);

      // Backpressure with ready pattern 1,0,0
      clear_mon();
      rdy_mode = 1; pat_k = 0;
      start_xfer(5'd5, 5'd2, 6'd6);
      wait_done("t3", 80);
      cyc();
      rdy_mode = 0;
      ev = '{16'h2515, 16'h2717, 16'h2919, 16'h2B1B, 16'h2D1D, 16'h2F1F, 16'h0, 16'h0};
      check_beats("t3", 6);
      check_vec("t3_hold_stable", hold_err, 0);
      check_vec("t3_buffer_bound", over_err, 0);
      check_vec("t3_done_count", done_n, 1);

      // Zero length, start held into the DONE cycle
      clear_mon();
      base_addr = 5'd0; stride = 5'd1; length = 6'd0; start = 1'b1;
      cyc(); cyc();
      start = 1'b0;
      cyc(); cyc();
      check_vec("t4_done_count", done_n, 1);
      check_vec("t4_done_lat", done_c - start_c, 1);
      check_vec("t4_no_rd_en", a_q.size(), 0);
      check_vec("t4_no_valid", valid_n, 0);
      check_vec("t4_busy_after", busy, 0);

      // Abort after two beats, then a clean restart
      clear_mon();
      start_xfer(5'd0, 5'd1, 6'd8);
      n = 0;
      while (b_data.size() < 2 && n < 30) begin
         cyc();
         n++;
      end
      check_vec("t5_two_beats", (b_data.size() >= 2) ? 1 : 0, 1);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      check_vec("t5_valid_after_abort", m_valid, 0);
      check_vec("t5_busy_after_abort", busy, 0);
      check_vec("t5_rd_en_after_abort", rd_en, 0);
      clear_mon();
      repeat (5) cyc();
      check_vec("t5_no_done", done_n, 0);
      check_vec("t5_no_stale_valid", valid_n, 0);
      check_vec("t5_no_reads", a_q.size(), 0);
      clear_mon();
      start_xfer(5'd0, 5'd1, 6'd2);
      wait_done("t5b", 30);
      cyc();
      ev = '{16'h2010, 16'h2111, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      check_beats("t5b", 2);

      // Start while busy is ignored
      clear_mon();
      start_xfer(5'd0, 5'd1, 6'd8);
      repeat (3) cyc();
      base_addr = 5'd10; stride = 5'd2; length = 6'd3; start = 1'b1;
      cyc();
      start = 1'b0;
      wait_done("t6a", 60);
      cyc();
      ev = '{16'h2010, 16'h2111, 16'h2212, 16'h2313, 16'h2414, 16'h2515, 16'h2616, 16'h2717};
      check_beats("t6a", 8);
      check_vec("t6a_reads", a_q.size(), 8);
      check_vec("t6a_done_count", done_n, 1);

      // Reset mid-transfer
      clear_mon();
      start_xfer(5'd4, 5'd1, 6'd8);
      repeat (4) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check_reset_outs("t6b_rst");
      clear_mon();
      repeat (4) cyc();
      check_vec("t6b_no_done", done_n, 0);
      check_vec("t6b_no_valid", valid_n, 0);
      check_vec("t6b_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
      $finish;
   end

endmodule
